// File: rtl/mem_access_ctrl_if.sv
// Signal bundle for mem_access_ctrl: pipeline-side request (mem_read,
// mem_write, load/store funct3, addr, store_data), the req/ready memory
// bus, and the pipeline results (load_data, stall, done, error pulses).
//   master : controller view (drives bus_*, load_data, stall, done, errs)
//   slave  : environment view (drives pipeline request and bus responses)
interface mem_access_ctrl_if;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  load_type;
  logic [2:0]  store_type;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic [31:0] load_data;
  logic        stall;
  logic        done;
  logic        misalign_err;
  logic        timeout_err;

  modport master (
    input  mem_read, mem_write, load_type, store_type, addr, store_data,
           bus_ready, bus_rdata,
    output bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
           load_data, stall, done, misalign_err, timeout_err
  );

  modport slave (
    output mem_read, mem_write, load_type, store_type, addr, store_data,
           bus_ready, bus_rdata,
    input  bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
           load_data, stall, done, misalign_err, timeout_err
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Multi-cycle data-memory sequencer between the pipeline's load/store
// control and a variable-latency req/ready memory bus.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   mif      : mem_access_ctrl_if.master (pipeline request, bus, results)
// Parameter TIMEOUT_CYCLES: REQ cycles without bus_ready before abort.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic               clk,
  input logic               rst,
  mem_access_ctrl_if.master mif
);
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          timeout_hit;
  logic          start;
  logic          legal;
  logic [3:0]    strb;
  logic [31:0]   wdat;
  logic [1:0]    lat_off;
  logic [2:0]    lat_lt;
  logic          lat_we;
  logic [15:0]   lane;
  logic [31:0]   ext;

  // Request decode: legality, strobes and replicated write data.
  always_comb begin
    start = mif.mem_read | mif.mem_write;
    legal = 1'b0;
    if (mif.mem_write) begin
      case (mif.store_type)
        3'b000:  legal = 1'b1;
        3'b001:  legal = ~mif.addr[0];
        3'b010:  legal = (mif.addr[1:0] == 2'b00);
        default: legal = 1'b0;
      endcase
    end else begin
      case (mif.load_type)
        3'b000, 3'b100: legal = 1'b1;
        3'b001, 3'b101: legal = ~mif.addr[0];
        3'b010:         legal = (mif.addr[1:0] == 2'b00);
        default:        legal = 1'b0;
      endcase
    end
    case (mif.store_type[1:0])
      2'b00: begin
        strb = 4'b0001 << mif.addr[1:0];
        wdat = {4{mif.store_data[7:0]}};
      end
      2'b01: begin
        strb = 4'b0011 << mif.addr[1:0];
        wdat = {2{mif.store_data[15:0]}};
      end
      default: begin
        strb = 4'b1111;
        wdat = mif.store_data;
      end
    endcase
  end

  // Load extraction from the latched byte offset and funct3.
  always_comb begin
    lane = 16'(mif.bus_rdata >> {lat_off, 3'b000});
    case (lat_lt)
      3'b000:  ext = {{24{lane[7]}}, lane[7:0]};
      3'b100:  ext = {24'd0, lane[7:0]};
      3'b001:  ext = {{16{lane[15]}}, lane[15:0]};
      3'b101:  ext = {16'd0, lane[15:0]};
      default: ext = mif.bus_rdata;
    endcase
  end

  assign cnt_inc     = cnt + CW'(1);
  assign timeout_hit = (cnt_inc == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    mif.stall  = 1'b0;
    case (state)
      IDLE: begin
        if (start && legal) begin
          state_next = REQ;
          mif.stall  = 1'b1;
        end
      end
      REQ: begin
        mif.stall = 1'b1;
        if (mif.bus_ready || timeout_hit) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered bus outputs, load result, pulses and REQ-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      mif.bus_req      <= 1'b0;
      mif.bus_we       <= 1'b0;
      mif.bus_addr     <= '0;
      mif.bus_wstrb    <= '0;
      mif.bus_wdata    <= '0;
      mif.load_data    <= '0;
      mif.done         <= 1'b0;
      mif.misalign_err <= 1'b0;
      mif.timeout_err  <= 1'b0;
      cnt              <= '0;
      lat_off          <= '0;
      lat_lt           <= '0;
      lat_we           <= 1'b0;
    end else begin
      mif.done         <= 1'b0;
      mif.misalign_err <= 1'b0;
      mif.timeout_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start && legal) begin
            mif.bus_req   <= 1'b1;
            mif.bus_we    <= mif.mem_write;
            mif.bus_addr  <= {mif.addr[31:2], 2'b00};
            mif.bus_wstrb <= mif.mem_write ? strb : 4'b0000;
            mif.bus_wdata <= mif.mem_write ? wdat : '0;
            lat_we        <= mif.mem_write;
            lat_off       <= mif.addr[1:0];
            lat_lt        <= mif.load_type;
            cnt           <= '0;
          end else if (start) begin
            mif.misalign_err <= 1'b1;
          end
        end
        REQ: begin
          cnt <= cnt_inc;
          if (mif.bus_ready) begin
            mif.bus_req <= 1'b0;
            mif.done    <= 1'b1;
            if (!lat_we) mif.load_data <= ext;
          end else if (timeout_hit) begin
            mif.bus_req     <= 1'b0;
            mif.done        <= 1'b1;
            mif.timeout_err <= 1'b1;
            if (!lat_we) mif.load_data <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl. A transaction-level model in the
// stimulus tasks derives per-cycle expectations from access size, byte
// offset and the REQ cycle on which the bus answers; a single compare
// process checks the DUT against them on every falling edge.
module tb_mem_access_ctrl;
  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_ctrl_if mif ();

  mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .mif (mif)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  logic        exp_req, exp_we, exp_stall, exp_done, exp_mis, exp_to;
  logic [31:0] exp_addr, exp_wdata, exp_load;
  logic [3:0]  exp_strb;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("stall", 32'(mif.stall), 32'(exp_stall));
      cmp("bus_req", 32'(mif.bus_req), 32'(exp_req));
      cmp("done", 32'(mif.done), 32'(exp_done));
      cmp("misalign_err", 32'(mif.misalign_err), 32'(exp_mis));
      cmp("timeout_err", 32'(mif.timeout_err), 32'(exp_to));
      cmp("load_data", mif.load_data, exp_load);
      if (exp_req) begin
        cmp("bus_we", 32'(mif.bus_we), 32'(exp_we));
        cmp("bus_addr", mif.bus_addr, exp_addr);
        cmp("bus_wstrb", 32'(mif.bus_wstrb), 32'(exp_strb));
        cmp("bus_wdata", mif.bus_wdata, exp_wdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // ---- model: access rules expressed as sizes and byte lanes ----
  function automatic int acc_size(input logic wr, input logic [2:0] lt, input logic [2:0] st);
    if (wr) return (st == 3'd0) ? 1 : (st == 3'd1) ? 2 : (st == 3'd2) ? 4 : 0;
    case (lt)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [3:0] m_strb(input int off, input int size);
    logic [3:0] s = '0;
    for (int b = 0; b < 4; b++) s[b] = (b >= off) && (b < off + size);
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] d, input int size);
    logic [31:0] w = '0;
    for (int b = 0; b < 4; b++) w[8*b +: 8] = d[8*(b % size) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rd, input int off,
                                         input int size, input logic is_unsigned);
    logic [31:0] v    = rd >> (8 * off);
    logic [31:0] mask = 32'hFFFF_FFFF >> (32 - 8 * size);
    v = v & mask;
    if (!is_unsigned && size < 4 && v[8*size-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic set_idle_exp();
    exp_req = 0; exp_stall = 0; exp_done = 0; exp_mis = 0; exp_to = 0;
  endtask

  task automatic idle(input int n);
    mif.mem_read = 0; mif.mem_write = 0; mif.bus_ready = 0;
    set_idle_exp();
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One access; ready_at = REQ cycle (1-based) on which bus_ready is given,
  // 0 = never. Returns right after the DONE (or misalign) cycle begins its
  // successor, leaving the caller to supply the next instruction.
  task automatic access(input logic rd, input logic wr, input logic [2:0] lt,
                        input logic [2:0] st, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] rdata,
                        input int ready_at);
    int  size = acc_size(wr, lt, st);
    int  off  = int'(a[1:0]);
    bit  ok   = (size != 0) && ((off % ((size == 0) ? 1 : size)) == 0);
    bit  got  = 0;
    mif.mem_read = rd; mif.mem_write = wr; mif.load_type = lt; mif.store_type = st;
    mif.addr = a; mif.store_data = d; mif.bus_ready = 0;
    set_idle_exp();
    exp_stall = ok;
    @(posedge clk); #1;
    if (!ok) begin
      mif.mem_read = 0; mif.mem_write = 0;
      set_idle_exp();
      exp_mis = 1;
      @(posedge clk); #1;
      exp_mis = 0;
      return;
    end
    exp_req = 1; exp_stall = 1; exp_we = wr;
    exp_addr  = {a[31:2], 2'b00};
    exp_strb  = wr ? m_strb(off, size) : 4'b0000;
    exp_wdata = wr ? m_wdata(d, size) : 32'h0;
    for (int i = 1; i <= int'(TO); i++) begin
      mif.bus_ready = (i == ready_at);
      mif.bus_rdata = (i == ready_at) ? rdata : ~rdata;
      @(posedge clk); #1;
      if (i == ready_at) begin got = 1; break; end
    end
    // DONE cycle: instruction and a stray bus_ready are still present.
    mif.bus_ready = 1; mif.bus_rdata = 32'hA5A5_5A5A;
    set_idle_exp();
    exp_done = 1;
    exp_to   = !got;
    if (!wr) exp_load = got ? m_load(rdata, off, size, lt[2]) : 32'h0;
    @(posedge clk); #1;
    mif.bus_ready = 0;
    set_idle_exp();
  endtask

  initial begin
    mif.mem_read = 0; mif.mem_write = 0; mif.load_type = 0; mif.store_type = 0;
    mif.addr = 0; mif.store_data = 0; mif.bus_ready = 0; mif.bus_rdata = 0;
    set_idle_exp();
    exp_we = 0; exp_addr = 0; exp_strb = 0; exp_wdata = 0; exp_load = 0;
    repeat (3) @(posedge clk);
    #1;
    cmp("rst_bus_req", 32'(mif.bus_req), 32'h0);
    cmp("rst_load_data", mif.load_data, 32'h0);
    cmp("rst_bus_wstrb", 32'(mif.bus_wstrb), 32'h0);
    cmp("rst_done", 32'(mif.done), 32'h0);
    rst = 0;
    chk_en = 1;
    idle(2);

    // 1: LW, ready on third REQ cycle
    access(1, 0, 3'b010, 3'b000, 32'h100, 32'h0, 32'hDEAD_BEEF, 3);
    cmp("lit_lw", mif.load_data, 32'hDEAD_BEEF);
    idle(1);

    // 2: byte/half extraction, back to back
    access(1, 0, 3'b000, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 1);
    cmp("lit_lb", mif.load_data, 32'hFFFF_FF80);
    access(1, 0, 3'b100, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 1);
    cmp("lit_lbu", mif.load_data, 32'h0000_0080);
    access(1, 0, 3'b001, 3'b000, 32'h102, 32'h0, 32'h80FF_1234, 2);
    cmp("lit_lh", mif.load_data, 32'hFFFF_80FF);
    access(1, 0, 3'b101, 3'b000, 32'h102, 32'h0, 32'h80FF_1234, 1);
    cmp("lit_lhu", mif.load_data, 32'h0000_80FF);
    access(1, 0, 3'b001, 3'b000, 32'h040, 32'h0, 32'h1234_7F01, 1);
    idle(1);

    // 3: stores; load_data must stay at 0x00007F01
    fork
      begin
        @(posedge clk); #2;
        cmp("lit_sh_addr", mif.bus_addr, 32'h200);
        cmp("lit_sh_strb", 32'(mif.bus_wstrb), 32'hC);
        cmp("lit_sh_wdata", mif.bus_wdata, 32'hABCD_ABCD);
        cmp("lit_sh_we", 32'(mif.bus_we), 32'h1);
      end
    join_none
    access(0, 1, 3'b000, 3'b001, 32'h202, 32'h1234_ABCD, 32'h0, 2);
    cmp("lit_sh_load_kept", mif.load_data, 32'h0000_7F01);
    access(0, 1, 3'b000, 3'b000, 32'h201, 32'h0000_0055, 32'h0, 1);
    access(1, 1, 3'b011, 3'b010, 32'h300, 32'hCAFE_F00D, 32'h0, 1);
    idle(1);

    // 4: illegal requests
    access(1, 0, 3'b010, 3'b000, 32'h101, 32'h0, 32'h0, 1);
    access(0, 1, 3'b000, 3'b001, 32'h007, 32'h0, 32'h0, 1);
    access(1, 0, 3'b011, 3'b000, 32'h100, 32'h0, 32'h0, 1);
    access(0, 1, 3'b000, 3'b011, 32'h100, 32'h0, 32'h0, 1);
    access(1, 0, 3'b111, 3'b000, 32'h100, 32'h0, 32'h0, 1);
    idle(1);

    // 5: timeout boundaries
    access(1, 0, 3'b010, 3'b000, 32'h500, 32'h0, 32'h1111_2222, TO);
    cmp("lit_ready_wins", mif.load_data, 32'h1111_2222);
    access(1, 0, 3'b010, 3'b000, 32'h504, 32'h0, 32'h3333_4444, 0);
    cmp("lit_timeout_load", mif.load_data, 32'h0);
    access(1, 0, 3'b100, 3'b000, 32'h508, 32'h0, 32'h0000_0099, 1);
    access(0, 1, 3'b000, 3'b010, 32'h50C, 32'h7777_8888, 32'h0, 0);
    cmp("lit_st_timeout_kept", mif.load_data, 32'h0000_0099);
    idle(1);

    // 6: reset during the second REQ cycle
    mif.mem_read = 1; mif.load_type = 3'b010; mif.addr = 32'h400;
    set_idle_exp(); exp_stall = 1;
    @(posedge clk); #1;
    exp_req = 1; exp_we = 0; exp_addr = 32'h400; exp_strb = 0; exp_wdata = 0;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0; mif.mem_read = 0;
    set_idle_exp(); exp_load = 0;
    cmp("lit_rst_bus_req", 32'(mif.bus_req), 32'h0);
    cmp("lit_rst_bus_addr", mif.bus_addr, 32'h0);
    idle(1);
    access(0, 1, 3'b000, 3'b010, 32'h600, 32'h0BAD_F00D, 32'h0, 2);
    idle(2);

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
